// File: rtl/xillybus_rd_sched.sv
// -----------------------------------------------------------------------------
// xillybus_rd_sched
//
// Purpose:
//   Multiplexes up to four requester FIFOs onto one upstream Xillybus read
//   stream. Sources are granted round-robin. Each grant produces one header
//   word followed by up to MAX_BURST data words copied from the granted
//   source FIFO. Back-pressure from the output FIFO is absorbed by a
//   one-entry hold register, so no word is lost, duplicated or reordered.
//
// Header word layout:
//   [31:24] 8'hA5   [23:18] zero   [17:16] source   [15:8] seq   [7:0] len
//
// Ports:
//   bus_clk     in   sole clock, rising edge
//   bus_rst     in   synchronous active-high reset
//   host_open   in   upstream read stream opened by the host
//   src_en      in   per-source enable
//   src_count   in   words held in each source FIFO, source i at [10i+9:10i]
//   src_data    in   read data of each source FIFO, source i at [32i+31:32i],
//                    valid the cycle after its src_rden
//   src_rden    out  read strobe per source FIFO, one-hot or zero
//   out_data    out  word written to the upstream output FIFO (0 when idle)
//   out_wren    out  write strobe to the upstream output FIFO
//   out_full    in   upstream output FIFO full
//   busy        out  high whenever the scheduler is not idle
//   cur_src     out  index of the granted source, held after the burst
//   burst_done  out  one-cycle pulse with the last data write of a burst
//   state_dbg   out  current FSM state (0 idle, 1 header, 2 data)
//
// Handshake: a word transfers to the output FIFO in any cycle where
// out_wren=1; out_wren is only ever raised while out_full=0. A source FIFO
// pops in any cycle where its src_rden=1 and returns the word on src_data in
// the following cycle.
// -----------------------------------------------------------------------------
module xillybus_rd_sched #(
    parameter int MAX_BURST = 64,
    parameter int NSRC      = 4
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic                 host_open,
    input  logic [NSRC-1:0]      src_en,
    input  logic [NSRC*10-1:0]   src_count,
    input  logic [NSRC*32-1:0]   src_data,
    output logic [NSRC-1:0]      src_rden,
    output logic [31:0]          out_data,
    output logic                 out_wren,
    input  logic                 out_full,
    output logic                 busy,
    output logic [1:0]           cur_src,
    output logic                 burst_done,
    output logic [1:0]           state_dbg
);

    localparam logic [9:0] MAXB10 = 10'(MAX_BURST);
    localparam logic [7:0] MAXB8  = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cur_src_q, cur_src_d;
    logic [1:0]             last_q, last_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             issued_q, issued_d;
    logic [7:0]             written_q, written_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [31:0]            hold_data_q, hold_data_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [NSRC-1:0][7:0]   seq_q, seq_d;

    logic [NSRC-1:0][9:0]   cnt;
    logic [NSRC-1:0][31:0]  dat;
    logic                   grant_found;
    logic [1:0]             grant_idx;
    logic [1:0]             cand;
    logic [9:0]             grant_cnt;
    logic [7:0]             grant_len;

    assign cnt = src_count;
    assign dat = src_data;

    // Rotating-priority search: first eligible source strictly after the
    // last granted one, wrapping around (the last-granted source is tried last).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = last_q;
        for (int k = 1; k <= NSRC; k++) begin
            cand = last_q + k[1:0];
            if (!grant_found && src_en[cand] && (cnt[cand] != 10'd0)) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_cnt = cnt[grant_idx];
        grant_len = (grant_cnt > MAXB10) ? MAXB8 : grant_cnt[7:0];
    end

    // Outputs are combinational from registered state because writes and
    // reads must be withheld in the very cycle out_full is high.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        last_d      = last_q;
        len_d       = len_q;
        issued_d    = issued_q;
        written_d   = written_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        rd_pend_d   = rd_pend_q;
        seq_d       = seq_q;
        src_rden    = '0;
        out_data    = 32'd0;
        out_wren    = 1'b0;
        burst_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_open && grant_found) begin
                    cur_src_d  = grant_idx;
                    last_d     = grant_idx;
                    len_d      = grant_len;
                    issued_d   = 8'd0;
                    written_d  = 8'd0;
                    hold_vld_d = 1'b0;
                    rd_pend_d  = 1'b0;
                    state_d    = S_HDR;
                end
            end

            S_HDR: begin
                if (!out_full) begin
                    out_wren           = 1'b1;
                    out_data           = {8'hA5, 6'd0, cur_src_q, seq_q[cur_src_q], len_q};
                    seq_d[cur_src_q]   = seq_q[cur_src_q] + 8'd1;
                    state_d            = S_DATA;
                end
            end

            S_DATA: begin
                rd_pend_d = 1'b0;
                // A held word and a word returning from the FIFO never coexist:
                // a read is only issued while the hold register is empty and
                // the output is not full, so it can only fill on the cycle after.
                if (hold_vld_q) begin
                    if (!out_full) begin
                        out_wren   = 1'b1;
                        out_data   = hold_data_q;
                        hold_vld_d = 1'b0;
                    end
                end else if (rd_pend_q) begin
                    if (!out_full) begin
                        out_wren = 1'b1;
                        out_data = dat[cur_src_q];
                    end else begin
                        hold_vld_d  = 1'b1;
                        hold_data_d = dat[cur_src_q];
                    end
                end

                if (!hold_vld_q && !out_full && (issued_q < len_q)) begin
                    src_rden[cur_src_q] = 1'b1;
                    issued_d            = issued_q + 8'd1;
                    rd_pend_d           = 1'b1;
                end

                if (out_wren) begin
                    written_d = written_q + 8'd1;
                    if (written_d == len_q) begin
                        burst_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q     <= S_IDLE;
            cur_src_q   <= 2'd0;
            last_q      <= 2'd3;
            len_q       <= 8'd0;
            issued_q    <= 8'd0;
            written_q   <= 8'd0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= 32'd0;
            rd_pend_q   <= 1'b0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            last_q      <= last_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            written_q   <= written_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            rd_pend_q   <= rd_pend_d;
            seq_q       <= seq_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign cur_src   = cur_src_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_xillybus_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_xillybus_rd_sched
//
// Self-checking bench for xillybus_rd_sched. Source FIFOs are modelled as
// queues that pop on src_rden and return the word one cycle later. A
// reference model works from word lists: it replays the round-robin grant
// rule over the words still owed by each source and builds the full
// expected output stream (headers and data) in exp_q. Every output write is
// compared in order against exp_q.
// -----------------------------------------------------------------------------
module tb_xillybus_rd_sched;

    localparam int MAXB = 64;

    logic          bus_clk = 1'b0;
    logic          bus_rst;
    logic          host_open;
    logic [3:0]    src_en;
    logic [39:0]   src_count;
    logic [127:0]  src_data;
    logic [3:0]    src_rden;
    logic [31:0]   out_data;
    logic          out_wren;
    logic          out_full;
    logic          busy;
    logic [1:0]    cur_src;
    logic          burst_done;
    logic [1:0]    state_dbg;

    xillybus_rd_sched #(.MAX_BURST(MAXB), .NSRC(4)) dut (
        .bus_clk    (bus_clk),
        .bus_rst    (bus_rst),
        .host_open  (host_open),
        .src_en     (src_en),
        .src_count  (src_count),
        .src_data   (src_data),
        .src_rden   (src_rden),
        .out_data   (out_data),
        .out_wren   (out_wren),
        .out_full   (out_full),
        .busy       (busy),
        .cur_src    (cur_src),
        .burst_done (burst_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 bus_clk = ~bus_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    logic [31:0] fifo_q [4][$];   // contents of the source FIFOs
    logic [31:0] mdl_q  [4][$];   // words the reference model still owes per source
    logic [7:0]  mdl_seq [4];
    logic [1:0]  mdl_last;
    logic [31:0] exp_q [$];
    logic [31:0] hdr_q [$];
    int          wr_cyc_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          cyc      = 0;
    int          data_wr  = 0;
    int          first_rd = -1;
    int          full_pct = 0;
    logic [3:0]  pend_rden = 4'd0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gen_expected(input logic [3:0] en, input int max_bursts);
        int nb;
        int g;
        int len;
        nb = 0;
        while (nb < max_bursts) begin
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (int'(mdl_last) + k) % 4;
                if (g < 0 && en[idx] && mdl_q[idx].size() > 0) g = idx;
            end
            if (g < 0) break;
            len = (mdl_q[g].size() < MAXB) ? mdl_q[g].size() : MAXB;
            exp_q.push_back({8'hA5, 6'd0, 2'(g), mdl_seq[g], 8'(len)});
            mdl_seq[g] = mdl_seq[g] + 8'd1;
            for (int k = 0; k < len; k++) exp_q.push_back(mdl_q[g].pop_front());
            mdl_last = 2'(g);
            nb++;
        end
        return nb;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            fifo_q[i].delete();
            mdl_q[i].delete();
            mdl_seq[i] = 8'd0;
        end
        mdl_last = 2'd3;
        exp_q.delete();
    endfunction

    // ---------------- drivers ----------------
    // One clock cycle: source FIFOs answer last cycle's strobes at the falling
    // edge, then outputs are sampled 1 ns later (stable until the next edge).
    task automatic step();
        logic [31:0] e;
        @(negedge bus_clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pend_rden[i]) begin
                if (fifo_q[i].size() > 0) src_data[32*i +: 32] = fifo_q[i].pop_front();
                else                      src_data[32*i +: 32] = 32'hDEAD_BEEF;
            end
            src_count[10*i +: 10] = 10'(fifo_q[i].size());
        end
        out_full = ($urandom_range(0, 99) < full_pct);
        #1;
        pend_rden = src_rden;
        if (bus_rst === 1'b0) begin
            check("rden_onehot", 32'($countones(src_rden) <= 1), 32'd1);
            if (out_wren) begin
                check("wren_while_full", 32'(out_full), 32'd0);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
                check("out_word", out_data, e);
                wr_cyc_q.push_back(cyc);
                if (out_data[31:24] == 8'hA5) hdr_q.push_back(out_data);
                else                          data_wr++;
            end
            if (src_rden != 4'd0 && first_rd < 0) first_rd = cyc;
            if (burst_done) n_done++;
        end
    endtask

    task automatic do_reset();
        bus_rst = 1'b1;
        model_reset();
        step();
        step();
        bus_rst   = 1'b0;
        pend_rden = 4'd0;
    endtask

    task automatic load(input int s, input int n);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = {4'hD, 2'b00, 2'(s), 24'($urandom)};
            fifo_q[s].push_back(w);
            mdl_q[s].push_back(w);
        end
    endtask

    task automatic drain(input int bursts, input string tag);
        int n;
        int done0;
        n     = 0;
        done0 = n_done;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 6000);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_bursts"}, 32'(n_done - done0), 32'(bursts));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        int t0;
        int n;
        int wrap;

        bus_rst   = 1'b1;
        host_open = 1'b0;
        src_en    = 4'd0;
        src_count = '0;
        src_data  = '0;
        out_full  = 1'b0;
        do_reset();

        // Reset state
        step();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_wren",  32'(out_wren), 32'd0);
        check("rst_rden",  32'(src_rden), 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_cur",   32'(cur_src), 32'd0);
        check("rst_done",  32'(burst_done), 32'd0);

        // Single source, 3 words: header, data, latency, second header
        host_open = 1'b1;
        src_en    = 4'b0001;
        load(0, 3);
        nb = gen_expected(src_en, 99);
        wr_cyc_q.delete();
        hdr_q.delete();
        first_rd = -1;
        t0 = cyc + 1;
        drain(nb, "s1");
        check("s1_nwr",     32'(wr_cyc_q.size()), 32'd4);
        check("s1_hdr",     hdr_q[0], 32'hA500_0003);
        check("s1_hdr_cyc", 32'(wr_cyc_q[0]), 32'(t0 + 1));
        check("s1_rd_cyc",  32'(first_rd), 32'(t0 + 2));
        check("s1_d0_cyc",  32'(wr_cyc_q[1]), 32'(t0 + 3));
        check("s1_d1_cyc",  32'(wr_cyc_q[2]), 32'(t0 + 4));
        check("s1_d2_cyc",  32'(wr_cyc_q[3]), 32'(t0 + 5));
        check("s1_cur",     32'(cur_src), 32'd0);
        load(0, 2);
        nb = gen_expected(src_en, 99);
        hdr_q.delete();
        drain(nb, "s1b");
        check("s1_hdr2", hdr_q[0], 32'hA500_0102);

        // Four sources x 200 words: round-robin order and burst lengths
        do_reset();
        src_en = 4'b1111;
        for (int s = 0; s < 4; s++) load(s, 200);
        nb = gen_expected(src_en, 999);
        hdr_q.delete();
        drain(nb, "s3");
        check("s3_nhdr", 32'(hdr_q.size()), 32'd16);
        for (int k = 0; k < 16 && k < hdr_q.size(); k++) begin
            check("s3_src", 32'(hdr_q[k][17:16]), 32'(k % 4));
            check("s3_seq", 32'(hdr_q[k][15:8]), 32'(k / 4));
            check("s3_len", 32'(hdr_q[k][7:0]), (k < 12) ? 32'h40 : 32'h08);
        end

        // Random back-pressure
        full_pct = 50;
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 4; s++) load(s, $urandom_range(1, 90));
            nb = gen_expected(src_en, 999);
            drain(nb, "s4");
        end
        full_pct = 0;

        // host_open gating and mid-burst drop
        host_open = 1'b0;
        src_en    = 4'b0100;
        load(2, 100);
        repeat (20) begin
            step();
            check("s5_closed_busy", 32'(busy), 32'd0);
            check("s5_closed_wren", 32'(out_wren), 32'd0);
        end
        host_open = 1'b1;
        nb = gen_expected(src_en, 1);
        hdr_q.delete();
        n = 0;
        while (hdr_q.size() == 0 && n < 50) begin
            step();
            n++;
        end
        host_open = 1'b0;
        drain(nb, "s5a");
        repeat (15) begin
            step();
            check("s5_after_busy", 32'(busy), 32'd0);
        end
        host_open = 1'b1;
        nb = gen_expected(src_en, 99);
        drain(nb, "s5b");

        // Reset in the middle of a 10-word burst
        src_en = 4'b0010;
        load(1, 10);
        nb = gen_expected(src_en, 1);
        data_wr = 0;
        n = 0;
        while (data_wr < 5 && n < 60) begin
            step();
            n++;
        end
        check("s6_words_before_rst", 32'(data_wr), 32'd5);
        bus_rst = 1'b1;
        model_reset();
        step();
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_wren", 32'(out_wren), 32'd0);
        check("s6_rst_rden", 32'(src_rden), 32'd0);
        check("s6_rst_data", out_data, 32'd0);
        check("s6_rst_cur",  32'(cur_src), 32'd0);
        check("s6_rst_done", 32'(burst_done), 32'd0);
        bus_rst   = 1'b0;
        pend_rden = 4'd0;
        src_en    = 4'b0011;
        load(0, 2);
        load(1, 2);
        nb = gen_expected(src_en, 99);
        hdr_q.delete();
        drain(nb, "s6");
        check("s6_first_hdr", hdr_q[0], 32'hA500_0002);

        // 257 single-word bursts from source 1: sequence wraps FF -> 00
        src_en = 4'b0010;
        hdr_q.delete();
        for (int b = 0; b < 257; b++) begin
            load(1, 1);
            nb = gen_expected(src_en, 1);
            drain(nb, "s7");
        end
        wrap = 0;
        for (int k = 0; k + 1 < hdr_q.size(); k++) begin
            if (hdr_q[k][15:8] == 8'hFF && hdr_q[k+1][15:8] == 8'h00) wrap++;
        end
        check("s7_nhdr", 32'(hdr_q.size()), 32'd257);
        check("s7_wrap", 32'(wrap), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xillybus_rd_sched.md
XILLYBUS_RD_SCHED -- requirements
Module: xillybus_rd_sched

Interface
REQ-001 SHALL have parameter MAX_BURST, default 64, max data words per grant (range 1..255).
REQ-002 SHALL have parameter NSRC, fixed 4, number of requester FIFOs.
REQ-003 SHALL have port bus_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port bus_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port host_open  in  1  upstream read stream opened by host (from user_r_rd_0_open).
REQ-006 SHALL have port src_en  in  4  per-source enable (from xcw_ctrl register).
REQ-007 SHALL have port src_count  in  4x10 (40, source i at [10i+9:10i])  words held in source FIFO i.
REQ-008 SHALL have port src_data  in  4x32 (128)  read data of source FIFO i, valid the cycle after its rden.
REQ-009 SHALL have port src_rden  out  4  read strobe to source FIFO i, one-hot or zero.
REQ-010 SHALL have port out_data  out  32  word to upstream output FIFO (feeds user_r_rd_0_data).
REQ-011 SHALL have port out_wren  out  1  write strobe to upstream output FIFO.
REQ-012 SHALL have port out_full  in  1  upstream output FIFO full; no write accepted when high.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port cur_src  out  2  index of granted source, held after burst end.
REQ-015 SHALL have port burst_done  out  1  one-cycle pulse when last data word of a burst is written.

Function
REQ-016 SHALL implement FSM states IDLE, HDR, DATA.
REQ-017 Source i SHALL be eligible when src_en[i]=1 and src_count[i]!=0.
REQ-018 In IDLE with host_open=1 and any eligible source, SHALL grant round-robin: first eligible source strictly after the last granted index, circular; after reset the last-granted index is 3 (source 0 first).
REQ-019 On grant SHALL latch cur_src, len = min(src_count[cur_src], MAX_BURST) (8 bits), and go to HDR next cycle.
REQ-020 With host_open=0 SHALL not leave IDLE; a burst already started SHALL complete regardless of host_open or src_en changes.
REQ-021 In HDR, when out_full=0, SHALL write header {8'hA5, 6'd0, cur_src, seq[cur_src], len} and go to DATA; when out_full=1 SHALL stay in HDR with out_wren=0.
REQ-022 SHALL keep an 8-bit seq counter per source, incremented on header write, wrapping 255->0.
REQ-023 In DATA, SHALL assert src_rden[cur_src] when issued<len, out_full=0, and hold register empty; issued increments per strobe.
REQ-024 Word returned the cycle after src_rden SHALL be written to out_data with out_wren=1 if out_full=0 that cycle, else captured into a 1-entry hold register.
REQ-025 Hold register SHALL be written out on the first cycle with out_full=0, with no new src_rden that cycle.
REQ-026 No word SHALL be lost, duplicated or reordered; out_wren SHALL never be high while out_full=1.
REQ-027 When written count reaches len, SHALL pulse burst_done and return to IDLE the next cycle.
REQ-028 Unstalled latency: grant cycle T, header written T+1, first src_rden T+2, first data write T+3, then one word per cycle.
REQ-029 src_count is trusted not to decrease during a burst; no underflow checking is done.

Reset
REQ-030 On bus_rst=1 at a clock edge SHALL enter IDLE, clear hold register, issued/written counters, all seq counters, set last-granted to 3, and drive src_rden=0, out_wren=0, out_data=0, busy=0, cur_src=0, burst_done=0.
REQ-031 Reset mid-burst SHALL abandon the burst without further src_rden or out_wren from the next cycle.

Verification
REQ-032 src_en=4'b0001, src_count0=3, host_open=1 -> outputs A500_0003, then 3 data words in order; burst_done once; second burst header A500_01xx.
REQ-033 All 4 sources enabled, count=200 each, MAX_BURST=64 -> grant order 0,1,2,3,0..., each header len 8'h40, last round len 8'h08.
REQ-034 Random out_full toggling during DATA -> data stream identical to source order, out_wren never high with out_full=1.
REQ-035 host_open=0 with eligible sources -> busy stays 0, no writes; drop host_open mid-burst -> burst completes, then idle.
REQ-036 bus_rst pulse at word 5 of a 10-word burst -> next cycle all outputs at reset values; next grant goes to source 0 with seq 0.
REQ-037 256 bursts from source 1 -> seq wraps 8'hFF to 8'h00 in header bits [15:8].
